// File: rtl/transpose_rd_ctr.sv
// transpose_rd_ctr: ping-pong transpose buffer between the IDCT row pass and
// the column pass. Raster-ordered words fill one 64-word bank while the other
// bank is read back column-major, either as one 8x8 block or as four 4x4
// sub-blocks, each transposed in place. Every output word is tagged with the
// mode that was latched when its bank started filling.
//
// Build option: define TRANSPOSE_4X4_EN to include the 4x4 read order.
// Without it, every non-idle mode is read in 8x8 order, and out_mode still
// reports the latched mode.
module transpose_rd_ctr #(
  parameter int WIDTH_X = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                idct_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_X-1:0] d_in,
  output logic                      out_valid,
  output logic [1:0]                out_mode,
  output logic                      out_last,
  output logic signed [WIDTH_X-1:0] d_out
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Storage: two banks, written in raster order, read with a permuted address
  logic signed [WIDTH_X-1:0] bank0_mem [64];
  logic signed [WIDTH_X-1:0] bank1_mem [64];

  // Bank bookkeeping
  logic [1:0] full;
  logic [1:0] full_n;
  logic [1:0] bank_mode [2];
  logic       wb;
  logic       rb;
  logic [5:0] w_addr;

  // Write-side handshake
  logic wr_acc;
  logic wr_drop;
  logic wr_en;
  logic wr_done;

  // Read-side sequencing
  rd_state_t  state;
  rd_state_t  state_n;
  logic [5:0] k;
  logic [5:0] k_n;
  logic       rd_en_p0;
  logic       rd_done;
  logic [5:0] rd_addr_p0;

  // Pipeline registers behind the address stage
  logic signed [WIDTH_X-1:0] rd_data_p1;
  logic [1:0]                mode_p1;
  logic                      vld_p1;
  logic                      last_p1;
  logic signed [WIDTH_X-1:0] dout_p2;
  logic [1:0]                mode_p2;
  logic                      vld_p2;
  logic                      last_p2;

  // 8x8 transpose: row and column fields of the raster address swap places.
  function automatic logic [5:0] addr_8x8(input logic [5:0] kk);
    return {kk[2:0], kk[5:3]};
  endfunction

`ifdef TRANSPOSE_4X4_EN
  // 4x4: the top two bits select the 16-word sub-block; the 2-bit row and
  // column fields inside it swap places.
  function automatic logic [5:0] addr_4x4(input logic [5:0] kk);
    return {kk[5:4], kk[1:0], kk[3:2]};
  endfunction

  function automatic logic [5:0] rd_addr_f(input logic [5:0] kk, input logic [1:0] m);
    return (m == 2'b01) ? addr_4x4(kk) : addr_8x8(kk);
  endfunction
`endif

  // Write side: the bank under wb accepts words until it is full. A
  // word arriving at address 0 with the idle mode is swallowed, so the block
  // only starts once a real mode is present; later mode changes are ignored.
  assign in_ready = ~full[wb];
  assign wr_acc   = in_valid & in_ready;
  assign wr_drop  = (w_addr == 6'd0) && (idct_mode == 2'b00);
  assign wr_en    = wr_acc & ~wr_drop;
  assign wr_done  = wr_en && (w_addr == 6'd63);

  // Full flags: the write side sets its bank and the read side clears its
  // bank; they never address the same bank in one cycle, so both apply.
  always_comb begin
    full_n = full;
    if (wr_done) full_n[wb] = 1'b1;
    if (rd_done) full_n[rb] = 1'b0;
  end

  // Read FSM next state: IDLE already issues address k=0 in the cycle it
  // sees a full bank, so the first read follows full by zero cycles and a
  // READ pass chains directly into the next full bank.
  always_comb begin
    state_n  = state;
    k_n      = k;
    rd_en_p0 = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE: begin
        if (full[rb]) begin
          rd_en_p0 = 1'b1;
          k_n      = k + 6'd1;
          state_n  = READ;
        end
      end
      READ: begin
        rd_en_p0 = 1'b1;
        if (k == 6'd63) begin
          rd_done = 1'b1;
          k_n     = 6'd0;
          state_n = full[~rb] ? READ : IDLE;
        end else begin
          k_n = k + 6'd1;
        end
      end
      default: begin
        state_n = IDLE;
        k_n     = 6'd0;
      end
    endcase
  end

`ifdef TRANSPOSE_4X4_EN
  assign rd_addr_p0 = rd_addr_f(k, bank_mode[rb]);
`else
  assign rd_addr_p0 = addr_8x8(k);
`endif

  // Control state: pointers, flags, latched modes and the read FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      full         <= 2'b00;
      wb           <= 1'b0;
      rb           <= 1'b0;
      w_addr       <= 6'd0;
      bank_mode[0] <= 2'b00;
      bank_mode[1] <= 2'b00;
      state        <= IDLE;
      k            <= 6'd0;
    end else begin
      full  <= full_n;
      state <= state_n;
      k     <= k_n;
      if (wr_en) begin
        w_addr <= w_addr + 6'd1;
        if (w_addr == 6'd0) bank_mode[wb] <= idct_mode;
      end
      if (wr_done) wb <= ~wb;
      if (rd_done) rb <= ~rb;
    end
  end

  // Bank write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wb) bank1_mem[w_addr] <= d_in;
      else    bank0_mem[w_addr] <= d_in;
    end
  end

  // ---- stage p0 -> p1: synchronous bank read ----
  // Read data and mode tag travel with the access
  always_ff @(posedge clk) begin
    if (rd_en_p0) begin
      rd_data_p1 <= rb ? bank1_mem[rd_addr_p0] : bank0_mem[rd_addr_p0];
      mode_p1    <= bank_mode[rb];
    end
  end

  // Valid and last markers for the read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_en_p0;
      last_p1 <= rd_done;
    end
  end

  // ---- stage p1 -> p2: output register ----
  // Data and mode hold while no word is presented; last is a one-cycle marker
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      mode_p2 <= 2'b00;
      dout_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        dout_p2 <= rd_data_p1;
        mode_p2 <= mode_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_last  = last_p2;
  assign out_mode  = mode_p2;
  assign d_out     = dout_p2;

endmodule

// File: tb/tb_transpose_rd_ctr.sv
// Testbench for transpose_rd_ctr: directed block table, hand-written
// multi-cycle sequences and a randomized run, all scored against a
// block-level model of expected output words, timing and in_ready.
module tb_transpose_rd_ctr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  idct_mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d_in;
  logic        out_valid;
  logic [1:0]  out_mode;
  logic        out_last;
  logic [15:0] d_out;

  transpose_rd_ctr #(.WIDTH_X(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .idct_mode (idct_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_mode  (out_mode),
    .out_last  (out_last),
    .d_out     (d_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit sb_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [15:0] d;
    logic [1:0]  m;
    bit          last;
  } exp_t;

  exp_t        exp_q [$];
  int          rend_q [$];   // cycle in which each full bank's last read is issued
  logic [15:0] blk [64];
  int          wcnt     = 0;
  logic [1:0]  bmode    = 2'b00;
  int          last_end = -100;
  logic [15:0] last_dout = 16'h0;
  logic [1:0]  last_mode = 2'b00;

  // Banks occupied during cycle m: completed and not yet released
  function automatic int nfull(input int m);
    int c = 0;
    foreach (rend_q[i]) if (rend_q[i] >= m) c++;
    return c;
  endfunction

  // Schedule the 64 transposed words of a bank completed in cycle n
  task automatic complete(input int n);
    int s, idx, r, c;
    bit is4;
    exp_t e;
    s = (n + 3 > last_end + 1) ? n + 3 : last_end + 1;
`ifdef TRANSPOSE_4X4_EN
    is4 = (bmode == 2'b01);
`else
    is4 = 1'b0;
`endif
    for (int j = 0; j < 64; j++) begin
      if (is4) begin
        r   = (j % 16) % 4;
        c   = (j % 16) / 4;
        idx = (j / 16) * 16 + r * 4 + c;
      end else begin
        r   = j % 8;
        c   = j / 8;
        idx = r * 8 + c;
      end
      e.cyc  = s + j;
      e.d    = blk[idx];
      e.m    = bmode;
      e.last = (j == 63);
      exp_q.push_back(e);
    end
    last_end = s + 63;
    rend_q.push_back(s + 61);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      rend_q.delete();
      wcnt      = 0;
      last_end  = -100;
      last_dout = 16'h0;
      last_mode = 2'b00;
    end else if (in_valid && (nfull(cyc) < 2)) begin
      if (!(wcnt == 0 && idct_mode == 2'b00)) begin
        if (wcnt == 0) bmode = idct_mode;
        blk[wcnt] = d_in;
        wcnt++;
        if (wcnt == 64) begin
          complete(cyc);
          wcnt = 0;
        end
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- capture for directed checks ----------------
  logic [15:0] cap  [256];
  int          capc [256];
  bit          capl [256];
  logic [1:0]  capm [256];
  int          ncap = 0;

  // Scoreboard and capture, sampled mid-cycle
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (sb_en) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("in_ready", {31'b0, in_ready}, {31'b0, nfull(cyc) < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (ev) begin
        e = exp_q.pop_front();
        chk("d_out", {16'b0, d_out}, {16'b0, e.d});
        chk("out_mode", {30'b0, out_mode}, {30'b0, e.m});
        chk("out_last", {31'b0, out_last}, {31'b0, e.last});
        last_dout = e.d;
        last_mode = e.m;
      end else begin
        chk("d_out_hold", {16'b0, d_out}, {16'b0, last_dout});
        chk("out_mode_hold", {30'b0, out_mode}, {30'b0, last_mode});
        chk("out_last_idle", {31'b0, out_last}, 32'd0);
      end
      if (out_valid && ncap < 256) begin
        cap[ncap]  = d_out;
        capc[ncap] = cyc;
        capl[ncap] = out_last;
        capm[ncap] = out_mode;
        ncap++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [1:0] m, input int pre, input int base, output int tstart);
    in_valid  = 1'b1;
    idct_mode = 2'b00;
    for (int i = 0; i < pre; i++) begin
      d_in = 16'hBEEF;
      tick();
    end
    idct_mode = m;
    tstart    = cyc;
    for (int i = 0; i < 64; i++) begin
      d_in = 16'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      tick();
      i++;
    end
    repeat (3) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic int count_last();
    int c = 0;
    for (int i = 0; i < ncap; i++) if (capl[i]) c++;
    return c;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0] mode;
    int         pre;
    logic [1:0] emode;
    int         e1;
    int         e4;
    int         e17;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int tstart;
    int lowcnt;

    tbl[0] = '{mode: 2'b10, pre: 0,  emode: 2'b10, e1: 8, e4: 32, e17: 10};
`ifdef TRANSPOSE_4X4_EN
    tbl[1] = '{mode: 2'b01, pre: 0,  emode: 2'b01, e1: 4, e4: 1,  e17: 20};
`else
    tbl[1] = '{mode: 2'b01, pre: 0,  emode: 2'b01, e1: 8, e4: 32, e17: 10};
`endif
    tbl[2] = '{mode: 2'b11, pre: 0,  emode: 2'b11, e1: 8, e4: 32, e17: 10};
    tbl[3] = '{mode: 2'b10, pre: 10, emode: 2'b10, e1: 8, e4: 32, e17: 10};

    rst       = 1'b1;
    in_valid  = 1'b0;
    idct_mode = 2'b00;
    d_in      = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_out_mode", {30'b0, out_mode}, 32'd0);
    chk("rst_d_out", {16'b0, d_out}, 32'd0);
    sb_en = 1'b1;

    // Single blocks from the table
    for (int v = 0; v < 4; v++) begin
      ncap = 0;
      run_block(tbl[v].mode, tbl[v].pre, 0, tstart);
      drain();
      chk("blk_count", ncap, 64);
      chk("blk_d0", {16'b0, cap[0]}, 32'd0);
      chk("blk_d1", {16'b0, cap[1]}, tbl[v].e1);
      chk("blk_d4", {16'b0, cap[4]}, tbl[v].e4);
      chk("blk_d17", {16'b0, cap[17]}, tbl[v].e17);
      chk("blk_d63", {16'b0, cap[63]}, 32'd63);
      chk("blk_mode", {30'b0, capm[0]}, {30'b0, tbl[v].emode});
      chk("blk_last63", {31'b0, capl[63]}, 32'd1);
      chk("blk_nlast", count_last(), 1);
      chk("blk_latency", capc[0] - tstart, 66);
      chk("blk_contig", capc[63] - capc[0], 63);
    end

    // Three back-to-back 8x8 blocks; the 129th word lands just as bank 0 frees
    ncap      = 0;
    lowcnt    = 0;
    in_valid  = 1'b1;
    idct_mode = 2'b10;
    for (int i = 0; i < 192; i++) begin
      d_in = 16'(i);
      if (!in_ready) lowcnt++;
      if (i == 128) chk("word129_ready", {31'b0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_ready_low", lowcnt, 0);
    chk("b2b_count", ncap, 192);
    chk("b2b_contig", capc[191] - capc[0], 191);
    chk("b2b_last64", {31'b0, capl[63]}, 32'd1);
    chk("b2b_last128", {31'b0, capl[127]}, 32'd1);
    chk("b2b_last192", {31'b0, capl[191]}, 32'd1);
    chk("b2b_nlast", count_last(), 3);
    chk("b2b_blk2_d0", {16'b0, cap[64]}, 32'd64);
    chk("b2b_blk2_d1", {16'b0, cap[65]}, 32'd72);
    chk("b2b_blk3_d8", {16'b0, cap[136]}, 32'd129);

    // Reset after 30 words, then a fresh block
    ncap      = 0;
    in_valid  = 1'b1;
    idct_mode = 2'b10;
    for (int i = 0; i < 30; i++) begin
      d_in = 16'(500 + i);
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_dout", {16'b0, d_out}, 32'd0);
    chk("mid_rst_mode", {30'b0, out_mode}, 32'd0);
    repeat (2) tick();
    run_block(2'b10, 0, 100, tstart);
    drain();
    chk("fresh_count", ncap, 64);
    chk("fresh_d0", {16'b0, cap[0]}, 32'd100);
    chk("fresh_d1", {16'b0, cap[1]}, 32'd108);
    chk("fresh_d8", {16'b0, cap[8]}, 32'd101);
    chk("fresh_latency", capc[0] - tstart, 66);

    // Randomized traffic with mode changes, idle drops and one reset
    idct_mode = 2'b10;
    for (int i = 0; i < 2500; i++) begin
      in_valid = (($urandom % 4) != 0);
      if (($urandom % 16) == 0) idct_mode = 2'($urandom % 4);
      d_in = 16'($urandom);
      rst  = (i == 1300);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
